// File: rtl/pinc_sweep_pkg.sv
// ---------------------------------------------------------------------------
// pinc_sweep_pkg
// Shared definitions for the phase-increment sweep generator:
//   sweep_state_e : controller states (IDLE, WAIT_ACK, DWELL)
//   MODE_SINGLE   : run one pass from start to stop, then pulse done
//   MODE_CONT     : wrap back to the start point after every pass
// ---------------------------------------------------------------------------
package pinc_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DWELL    = 2'd2
  } sweep_state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/sweep_dwell_cnt.sv
// ---------------------------------------------------------------------------
// sweep_dwell_cnt
// Loadable down-counter that times how long each sweep point is held.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val on this edge (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one; the count saturates at zero
//   zero     : count is zero
// ---------------------------------------------------------------------------
module sweep_dwell_cnt #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [width-1:0] count;

  // Saturating at zero keeps the flag asserted until the controller
  // reloads the counter for the next point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - width'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pinc_sweep_gen.sv
// ---------------------------------------------------------------------------
// pinc_sweep_gen
// Steps a phase increment from a start value up to an inclusive stop value.
// Each point is offered to the DDS stage over an AXI-stream-like handshake
// and then held for a dwell time after it is accepted.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   cfg_start_pinc        : first sweep point
//   cfg_stop_pinc         : inclusive upper limit
//   cfg_step              : unsigned increment between points
//   cfg_dwell             : cycles each point is held after acceptance (0 acts as 1)
//   cfg_mode              : MODE_SINGLE or MODE_CONT
//   start                 : launch request, only honoured in IDLE
//   abort                 : cancel the sweep; beats start and tready
//   pinc_axis_tdata/valid : current point and its not-yet-accepted flag
//   pinc_axis_tready      : DDS stage accepts the point
//   busy                  : sweep in progress
//   done                  : one-cycle pulse when a single sweep finishes
// ---------------------------------------------------------------------------
module pinc_sweep_gen
  import pinc_sweep_pkg::*;
#(
  parameter int pinc_width  = 16,
  parameter int dwell_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [pinc_width-1:0]  cfg_start_pinc,
  input  logic [pinc_width-1:0]  cfg_stop_pinc,
  input  logic [pinc_width-1:0]  cfg_step,
  input  logic [dwell_width-1:0] cfg_dwell,
  input  logic                   cfg_mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [pinc_width-1:0]  pinc_axis_tdata,
  output logic                   pinc_axis_tvalid,
  input  logic                   pinc_axis_tready,
  output logic                   busy,
  output logic                   done
);

  sweep_state_e state;

  // Configuration captured at launch so later cfg_* changes cannot disturb
  // a sweep that is already running.
  logic [pinc_width-1:0]  start_q;
  logic [pinc_width-1:0]  stop_q;
  logic [pinc_width-1:0]  step_q;
  logic [dwell_width-1:0] dwell_q;
  logic                   mode_q;

  logic [pinc_width:0]    sum;
  logic                   next_ok;
  logic [dwell_width-1:0] dwell_load;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   dwell_zero;

  // The extra top bit keeps a sum that overflows pinc_width above any stop
  // value, so a sweep near the top of the range ends instead of wrapping.
  assign sum     = {1'b0, pinc_axis_tdata} + {1'b0, step_q};
  assign next_ok = (sum <= {1'b0, stop_q}) && (step_q != '0);

  // Loading dwell-1 places the decision exactly dwell edges after the
  // accept; a dwell of zero behaves as a dwell of one.
  assign dwell_load = (dwell_q == '0) ? '0 : (dwell_q - dwell_width'(1));
  assign cnt_load   = (state == WAIT_ACK) && pinc_axis_tvalid && pinc_axis_tready && !abort;
  assign cnt_dec    = (state == DWELL) && !abort;

  sweep_dwell_cnt #(
    .width(dwell_width)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (dwell_load),
    .dec      (cnt_dec),
    .zero     (dwell_zero)
  );

  // Sweep controller. Abort overrides everything else and leaves tdata
  // untouched so the DDS stage keeps its last programmed frequency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pinc_axis_tdata  <= '0;
      pinc_axis_tvalid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      start_q          <= '0;
      stop_q           <= '0;
      step_q           <= '0;
      dwell_q          <= '0;
      mode_q           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state            <= IDLE;
        pinc_axis_tvalid <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              start_q          <= cfg_start_pinc;
              stop_q           <= cfg_stop_pinc;
              step_q           <= cfg_step;
              dwell_q          <= cfg_dwell;
              mode_q           <= cfg_mode;
              pinc_axis_tdata  <= cfg_start_pinc;
              pinc_axis_tvalid <= 1'b1;
              busy             <= 1'b1;
              state            <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (pinc_axis_tready) begin
              pinc_axis_tvalid <= 1'b0;
              state            <= DWELL;
            end
          end
          DWELL: begin
            if (dwell_zero) begin
              if (next_ok) begin
                pinc_axis_tdata  <= sum[pinc_width-1:0];
                pinc_axis_tvalid <= 1'b1;
                state            <= WAIT_ACK;
              end else if (mode_q == MODE_CONT) begin
                pinc_axis_tdata  <= start_q;
                pinc_axis_tvalid <= 1'b1;
                state            <= WAIT_ACK;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pinc_sweep_gen.sv
// ---------------------------------------------------------------------------
// tb_pinc_sweep_gen
// Self-checking bench for pinc_sweep_gen: a cycle-level behavioural model of
// the sweep rules is compared against the DUT every cycle, and directed
// scenarios check accepted point sequences, spacing and pulses against
// hand-computed literals.
// ---------------------------------------------------------------------------
module tb_pinc_sweep_gen;

  localparam int PW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] cfg_start_pinc;
  logic [PW-1:0] cfg_stop_pinc;
  logic [PW-1:0] cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_mode;
  logic          start;
  logic          abort;
  logic [PW-1:0] pinc_axis_tdata;
  logic          pinc_axis_tvalid;
  logic          pinc_axis_tready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pinc_sweep_gen #(
    .pinc_width (PW),
    .dwell_width(DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start_pinc  (cfg_start_pinc),
    .cfg_stop_pinc   (cfg_stop_pinc),
    .cfg_step        (cfg_step),
    .cfg_dwell       (cfg_dwell),
    .cfg_mode        (cfg_mode),
    .start           (start),
    .abort           (abort),
    .pinc_axis_tdata (pinc_axis_tdata),
    .pinc_axis_tvalid(pinc_axis_tvalid),
    .pinc_axis_tready(pinc_axis_tready),
    .busy            (busy),
    .done            (done)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Behavioural model: the sweep described as a busy flag, a pending-offer
  // flag, the current point as a plain integer and the number of dwell
  // cycles still to wait.
  int mData, mStart, mStop, mStep, mDwell, mDwellLeft;
  bit mMode, mBusy, mValid, mDone;

  function automatic int dwellOf(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mData <= 0; mStart <= 0; mStop <= 0; mStep <= 0; mDwell <= 0;
      mDwellLeft <= 0; mMode <= 0; mBusy <= 0; mValid <= 0; mDone <= 0;
    end else begin
      mDone <= 0;
      if (abort) begin
        mBusy  <= 0;
        mValid <= 0;
      end else if (!mBusy) begin
        if (start) begin
          mStart <= int'(cfg_start_pinc);
          mStop  <= int'(cfg_stop_pinc);
          mStep  <= int'(cfg_step);
          mDwell <= int'(cfg_dwell);
          mMode  <= cfg_mode;
          mData  <= int'(cfg_start_pinc);
          mValid <= 1;
          mBusy  <= 1;
        end
      end else if (mValid) begin
        if (pinc_axis_tready) begin
          mValid     <= 0;
          mDwellLeft <= dwellOf(mDwell);
        end
      end else if (mDwellLeft > 1) begin
        mDwellLeft <= mDwellLeft - 1;
      end else if (mStep != 0 && (mData + mStep) <= mStop) begin
        mData  <= mData + mStep;
        mValid <= 1;
      end else if (mMode) begin
        mData  <= mStart;
        mValid <= 1;
      end else begin
        mDone <= 1;
        mBusy <= 0;
      end
    end
  end

  // Accept log: every handshake edge records the point and the cycle number.
  int cyc = 0;
  int accData[$];
  int accCyc[$];
  int doneSeen = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && pinc_axis_tvalid && pinc_axis_tready) begin
      accData.push_back(int'(pinc_axis_tdata));
      accCyc.push_back(cyc);
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model tdata", int'(pinc_axis_tdata), mData);
      checkOutput("model tvalid", int'(pinc_axis_tvalid), int'(mValid));
      checkOutput("model busy", int'(busy), int'(mBusy));
      checkOutput("model done", int'(done), int'(mDone));
      if (done) doneSeen++;
    end
  end

  // Launch a sweep, then scramble cfg_* so a running sweep must ignore them.
  task automatic applyStimulus(input int s, input int e, input int st, input int dw, input bit md);
    @(negedge clk);
    cfg_start_pinc = PW'(s);
    cfg_stop_pinc  = PW'(e);
    cfg_step       = PW'(st);
    cfg_dwell      = DW'(dw);
    cfg_mode       = md;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
    cfg_start_pinc = 16'h5555;
    cfg_stop_pinc  = 16'h0000;
    cfg_step       = 16'h0001;
    cfg_dwell      = 16'd0;
    cfg_mode       = ~md;
  endtask

  task automatic pulseAbort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic waitAccepts(input int base, input int n, input string name);
    int k = 0;
    while ((accData.size() - base) < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if ((accData.size() - base) < n)
      checkOutput({name, " accept timeout"}, accData.size() - base, n);
  endtask

  task automatic waitIdle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checkOutput({name, " busy cleared"}, int'(busy), 0);
  endtask

  initial begin
    static int exp1[4] = '{100, 110, 120, 130};
    static int exp2[6] = '{100, 110, 120, 130, 100, 110};
    int base;
    int d0;

    rst = 1'b1;
    cfg_start_pinc = '0; cfg_stop_pinc = '0; cfg_step = '0; cfg_dwell = '0;
    cfg_mode = 1'b0; start = 1'b0; abort = 1'b0; pinc_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset tdata", int'(pinc_axis_tdata), 0);
    checkOutput("reset tvalid", int'(pinc_axis_tvalid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);

    $display("[TB] single sweep 100..130 step 10 dwell 3");
    base = accData.size(); d0 = doneSeen;
    applyStimulus(100, 130, 10, 3, 1'b0);
    waitAccepts(base, 4, "single");
    waitIdle("single");
    checkOutput("single count", accData.size() - base, 4);
    for (int i = 0; i < 4 && base + i < accData.size(); i++)
      checkOutput("single point", accData[base + i], exp1[i]);
    for (int i = 0; i < 3 && base + i + 1 < accData.size(); i++)
      checkOutput("single spacing", accCyc[base + i + 1] - accCyc[base + i], 4);
    checkOutput("single done pulses", doneSeen - d0, 1);
    checkOutput("single last tdata", int'(pinc_axis_tdata), 130);

    $display("[TB] continuous sweep");
    base = accData.size(); d0 = doneSeen;
    applyStimulus(100, 130, 10, 3, 1'b1);
    waitAccepts(base, 6, "cont");
    for (int i = 0; i < 6 && base + i < accData.size(); i++)
      checkOutput("cont point", accData[base + i], exp2[i]);
    checkOutput("cont no done", doneSeen - d0, 0);
    pulseAbort();
    checkOutput("cont abort busy", int'(busy), 0);
    checkOutput("cont abort tvalid", int'(pinc_axis_tvalid), 0);

    $display("[TB] tready stall on 110");
    base = accData.size();
    applyStimulus(100, 130, 10, 3, 1'b0);
    waitAccepts(base, 1, "stall");
    pinc_axis_tready = 1'b0;
    for (int k = 0; k < 50 && !pinc_axis_tvalid; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall tvalid", int'(pinc_axis_tvalid), 1);
      checkOutput("stall tdata", int'(pinc_axis_tdata), 110);
      if (i < 9) @(negedge clk);
    end
    pinc_axis_tready = 1'b1;
    waitAccepts(base, 3, "stall");
    if (accData.size() - base >= 3) begin
      checkOutput("stall accepted", accData[base + 1], 110);
      checkOutput("stall dwell after accept", accCyc[base + 2] - accCyc[base + 1], 4);
    end
    waitIdle("stall");
    checkOutput("stall count", accData.size() - base, 4);

    $display("[TB] top-of-range sweep");
    base = accData.size(); d0 = doneSeen;
    applyStimulus(16'hFFF0, 16'hFFFF, 16'h0020, 3, 1'b0);
    waitIdle("top");
    checkOutput("top count", accData.size() - base, 1);
    if (accData.size() > base) checkOutput("top point", accData[base], 16'hFFF0);
    checkOutput("top tdata held", int'(pinc_axis_tdata), 16'hFFF0);
    checkOutput("top done pulses", doneSeen - d0, 1);

    $display("[TB] zero step");
    base = accData.size();
    applyStimulus(100, 130, 0, 2, 1'b0);
    waitIdle("step0");
    checkOutput("step0 count", accData.size() - base, 1);

    $display("[TB] abort during dwell of 120");
    base = accData.size(); d0 = doneSeen;
    applyStimulus(100, 130, 10, 3, 1'b0);
    waitAccepts(base, 3, "abort");
    pulseAbort();
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort tvalid", int'(pinc_axis_tvalid), 0);
    checkOutput("abort tdata", int'(pinc_axis_tdata), 120);
    repeat (5) @(negedge clk);
    checkOutput("abort no done", doneSeen - d0, 0);
    checkOutput("abort tdata stable", int'(pinc_axis_tdata), 120);
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start+abort busy", int'(busy), 0);
    applyStimulus(100, 130, 10, 3, 1'b0);
    checkOutput("restart tdata", int'(pinc_axis_tdata), 100);
    checkOutput("restart tvalid", int'(pinc_axis_tvalid), 1);
    waitIdle("restart");

    $display("[TB] reset during WAIT_ACK");
    pinc_axis_tready = 1'b0;
    applyStimulus(100, 130, 10, 3, 1'b0);
    checkOutput("pre-reset tvalid", int'(pinc_axis_tvalid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1; start = 1'b1;
    #1;
    checkOutput("async reset tdata", int'(pinc_axis_tdata), 0);
    checkOutput("async reset tvalid", int'(pinc_axis_tvalid), 0);
    checkOutput("async reset busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0; pinc_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post-reset busy", int'(busy), 0);
    checkOutput("post-reset tvalid", int'(pinc_axis_tvalid), 0);

    $display("[TB] zero dwell");
    base = accData.size();
    applyStimulus(200, 210, 10, 0, 1'b0);
    waitIdle("dwell0");
    checkOutput("dwell0 count", accData.size() - base, 2);
    if (accData.size() - base >= 2) begin
      checkOutput("dwell0 second", accData[base + 1], 210);
      checkOutput("dwell0 spacing", accCyc[base + 1] - accCyc[base], 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pinc_sweep_gen.md
PINC_SWEEP_GEN -- requirements
Module: pinc_sweep_gen

Interface
REQ-001 The block SHALL have parameter pinc_width, default 16: width of every phase-increment word and of pinc_axis_tdata.
REQ-002 The block SHALL have parameter dwell_width, default 16: width of the dwell-time word.
REQ-003 The block SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port cfg_start_pinc, input, pinc_width: first sweep point.
REQ-006 The block SHALL have port cfg_stop_pinc, input, pinc_width: inclusive upper sweep limit.
REQ-007 The block SHALL have port cfg_step, input, pinc_width: unsigned increment between points.
REQ-008 The block SHALL have port cfg_dwell, input, dwell_width: cycles each point is held after acceptance.
REQ-009 The block SHALL have port cfg_mode, input, 1: 0 = single sweep, 1 = continuous wrap.
REQ-010 The block SHALL have port start, input, 1: one-cycle sweep launch request.
REQ-011 The block SHALL have port abort, input, 1: sweep cancel request.
REQ-012 The block SHALL have port pinc_axis_tdata, output, pinc_width: phase increment for the parallel DDS stage.
REQ-013 The block SHALL have port pinc_axis_tvalid, output, 1: tdata carries a new, unaccepted point.
REQ-014 The block SHALL have port pinc_axis_tready, input, 1: the DDS stage accepts the point.
REQ-015 The block SHALL have port busy, output, 1: sweep in progress.
REQ-016 The block SHALL have port done, output, 1: one-cycle pulse when a single sweep completes.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_ACK and DWELL.
REQ-018 In IDLE, start=1 and abort=0 SHALL latch all cfg_* into shadow registers, load tdata with cfg_start_pinc, set tvalid=1 and busy=1, and go to WAIT_ACK on that edge.
REQ-019 cfg_* changes after launch SHALL have no effect until the next launch.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 In WAIT_ACK, tvalid and tdata SHALL hold until tvalid&tready.
REQ-022 On the tvalid&tready edge k, tvalid SHALL clear and the FSM SHALL enter DWELL with counter = max(dwell,1)-1; cfg_dwell=0 is treated as 1.
REQ-023 In DWELL, the counter SHALL decrement each cycle; the next-point decision SHALL occur on edge k+max(dwell,1).
REQ-024 The next-point sum SHALL be computed as tdata+step in pinc_width+1 bits, so there is no wrap-around.
REQ-025 If sum <= stop and step != 0, tdata SHALL become sum, tvalid=1, and the FSM SHALL go to WAIT_ACK.
REQ-026 Otherwise (end of sweep), in mode 1 tdata SHALL reload start, tvalid=1, and the FSM SHALL go to WAIT_ACK.
REQ-027 At end of sweep in mode 0, done SHALL pulse for 1 cycle, busy SHALL clear, the FSM SHALL go to IDLE, and tdata SHALL keep the last point.
REQ-028 When start_pinc > stop_pinc, only start_pinc SHALL be issued before end of sweep.
REQ-029 When step = 0, only start_pinc SHALL be issued per pass.
REQ-030 abort=1 in any state SHALL, on that edge, go to IDLE, clear tvalid and busy, hold tdata, and not pulse done.
REQ-031 When abort and start are asserted in the same cycle, abort SHALL win.
REQ-032 When abort coincides with tready, the abort SHALL win; the point counts as accepted by the DDS stage, and the block takes no further action.
REQ-033 In IDLE, tdata SHALL remain stable so the DDS stage sees no spurious change.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE, tdata=0, tvalid=0, busy=0, done=0, counter=0, and shadow registers=0.
REQ-035 Reset mid-sweep SHALL discard the sweep; after release the block SHALL wait for a new start.

Structure
REQ-036 Package pinc_sweep_pkg SHALL hold the state encoding (IDLE/WAIT_ACK/DWELL) and the mode constants (MODE_SINGLE=0, MODE_CONT=1).
REQ-037 The block SHALL contain one sub-module, sweep_dwell_cnt, a loadable down-counter with a zero flag; all other logic SHALL be in pinc_sweep_gen.

Verification
REQ-038 The bench SHALL cover: start=100, stop=130, step=10, dwell=3, mode 0, tready=1 -> tdata 100,110,120,130 with accepts 4 cycles apart, then done 1 cycle and busy low.
REQ-039 The bench SHALL cover: the same settings with mode 1 -> after 130 the next point is 100; no done pulse; runs until abort.
REQ-040 The bench SHALL cover: tready held low 10 cycles on point 110 -> tvalid/tdata stable 10 cycles, and dwell starts only after the accept.
REQ-041 The bench SHALL cover: start=0xFFF0, stop=0xFFFF, step=0x20, mode 0 -> only 0xFFF0 issued (no wrap), then done.
REQ-042 The bench SHALL cover: abort during DWELL of 120 -> next edge busy=0, tvalid=0, tdata=120, no done; a subsequent start restarts at start_pinc.
REQ-043 The bench SHALL cover: rst pulse mid-WAIT_ACK -> tdata=0, tvalid=0 immediately (asynchronous); a start during rst is ignored.
